// File: rtl/encoder_speed_sched.sv
// Gated-window encoder speed meter: per-channel edge counters, one shared 8-step shift-add scaler,
// one 8-bit rpm result per channel per window on a valid/ready stream. Define ENC_TICK_SYNC_EN for 2-flop tick synchronizers.
module encoder_speed_sched #(
    parameter int NCH        = 4,
    parameter int WIN_CYCLES = 50000,
    parameter int CNT_W      = 16,
    parameter int MULT       = 3,
    parameter int SHIFT      = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [NCH-1:0]   ticks_i,
    output logic [7:0]       rpm_o,
    output logic [2:0]       rpm_ch_o,
    output logic             rpm_valid_o,
    input  logic             rpm_ready_i,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int              WIN_W   = $clog2(WIN_CYCLES);
    localparam int              PROD_W  = CNT_W + 8;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [7:0]      MULT_B  = 8'(MULT);
    localparam logic [2:0]      LAST_CH = 3'(NCH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [NCH-1:0]   tick_cur;
    logic [NCH-1:0]   tick_prev_q;
    logic [NCH-1:0]   pulse;
    logic [WIN_W-1:0] win_q;
    logic             win_end;
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_inc [NCH];
    logic [CNT_W-1:0] snap_q  [NCH];
    logic [CNT_W-1:0] snap_sel;

    logic [1:0]        state_q, state_d;
    logic [2:0]        ch_q, ch_d;
    logic [2:0]        bit_q, bit_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [PROD_W-1:0] acc_sum;
    logic [PROD_W-1:0] prod_sh;
    logic [7:0]        rpm_sat;
    logic [7:0]        rpm_q, rpm_d;
    logic [2:0]        rpm_ch_q, rpm_ch_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

`ifdef ENC_TICK_SYNC_EN
    logic [NCH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= ticks_i;
            sync2_q <= sync1_q;
        end
    end

    assign tick_cur = sync2_q;
`else
    assign tick_cur = ticks_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) tick_prev_q <= '0;
        else       tick_prev_q <= tick_cur;
    end

    assign pulse   = tick_cur & ~tick_prev_q;
    assign win_end = enable_i && (win_q == WIN_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                       win_q <= '0;
        else if (!enable_i || win_end)   win_q <= '0;
        else                             win_q <= win_q + WIN_W'(1);
    end

    // Saturating increment; the closing cycle's pulse is folded into the snapshot.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            cnt_inc[i] = cnt_q[i];
            if (pulse[i] && (cnt_q[i] != '1)) cnt_inc[i] = cnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                     cnt_q <= '{default: '0};
        else if (!enable_i || win_end) cnt_q <= '{default: '0};
        else                           cnt_q <= cnt_inc;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                             snap_q <= '{default: '0};
        else if (win_end && state_q == S_IDLE) snap_q <= cnt_inc;
    end

    always_comb begin
        snap_sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_q == 3'(i)) snap_sel = snap_q[i];
        end
    end

    assign acc_sum = MULT_B[bit_q] ? (acc_q + (PROD_W'(snap_sel) << bit_q)) : acc_q;
    assign prod_sh = acc_sum >> SHIFT;
    assign rpm_sat = (prod_sh > PROD_W'(255)) ? 8'hFF : prod_sh[7:0];

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        bit_d     = bit_q;
        acc_d     = acc_q;
        rpm_d     = rpm_q;
        rpm_ch_d  = rpm_ch_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (win_end) begin
                    state_d = S_MUL;
                    ch_d    = '0;
                    bit_d   = '0;
                    acc_d   = '0;
                end
            end
            S_MUL: begin
                acc_d = acc_sum;
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d  = S_OUT;
                    rpm_d    = rpm_sat;
                    rpm_ch_d = ch_q;
                    valid_d  = 1'b1;
                end
            end
            S_OUT: begin
                if (rpm_ready_i) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    bit_d   = '0;
                    if (ch_q == LAST_CH) begin
                        state_d = S_IDLE;
                    end else begin
                        ch_d    = ch_q + 3'd1;
                        state_d = S_MUL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A window closing mid-sequence is lost; only the sticky flag records it.
        if (win_end && state_q != S_IDLE) overrun_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            bit_q     <= '0;
            acc_q     <= '0;
            rpm_q     <= '0;
            rpm_ch_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            bit_q     <= bit_d;
            acc_q     <= acc_d;
            rpm_q     <= rpm_d;
            rpm_ch_q  <= rpm_ch_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rpm_o       = rpm_q;
    assign rpm_ch_o    = rpm_ch_q;
    assign rpm_valid_o = valid_q;
    assign busy_o      = (state_q != S_IDLE);
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_encoder_speed_sched.sv
// Bench for encoder_speed_sched: window/queue reference model checked every cycle, plus directed literal checks.
module tb_encoder_speed_sched;

    localparam int NCH   = 4;
    localparam int WIN   = 1000;
    localparam int CNT_W = 8;
    localparam int MULT  = 3;
    localparam int SHIFT = 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic           rpm_ready = 1'b1;
    logic [NCH-1:0] ticks = '0;
    logic [7:0]     rpm;
    logic [2:0]     rpm_ch;
    logic           rpm_valid, busy, overrun;

    always #5 clk = ~clk;

    encoder_speed_sched #(
        .NCH(NCH), .WIN_CYCLES(WIN), .CNT_W(CNT_W), .MULT(MULT), .SHIFT(SHIFT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .ticks_i(ticks),
        .rpm_o(rpm), .rpm_ch_o(rpm_ch), .rpm_valid_o(rpm_valid),
        .rpm_ready_i(rpm_ready), .busy_o(busy), .overrun_o(overrun)
    );

    int tests = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int scale(input int c);
        int r;
        r = (c * MULT) >> SHIFT;
        if (r > 255) r = 255;
        return r;
    endfunction

    // Reference model: window position, per-channel edge tallies and a queue of pending results.
    typedef struct { int ch; int rpm; } ent_t;
    ent_t mq[$];
    ent_t ent;
    int   mcyc = 0, m_ready_at = 0, m_win = 0;
    int   mcnt [NCH];
    bit   mprev[NCH];
    int   m_ovr = 0, m_rpm = 0, m_ch = 0;
    int   c_new;
    bit   e_busy, e_valid, wend, pls;

    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            m_win = 0; m_ovr = 0; m_rpm = 0; m_ch = 0;
            for (int i = 0; i < NCH; i++) begin mcnt[i] = 0; mprev[i] = 1'b0; end
            chk("rst_rpm", int'(rpm), 0);
            chk("rst_rpm_ch", int'(rpm_ch), 0);
            chk("rst_valid", int'(rpm_valid), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_overrun", int'(overrun), 0);
        end else begin
            e_busy  = (mq.size() > 0);
            e_valid = e_busy && (mcyc >= m_ready_at);
            if (e_busy && mcyc == m_ready_at) begin
                m_rpm = mq[0].rpm;
                m_ch  = mq[0].ch;
            end
            chk("busy", int'(busy), int'(e_busy));
            chk("rpm_valid", int'(rpm_valid), int'(e_valid));
            chk("overrun", int'(overrun), m_ovr);
            chk("rpm", int'(rpm), m_rpm);
            chk("rpm_ch", int'(rpm_ch), m_ch);

            wend = enable && (m_win == WIN - 1);
            for (int i = 0; i < NCH; i++) begin
                pls = enable && ticks[i] && !mprev[i];
                mprev[i] = ticks[i];
                c_new = (pls && mcnt[i] < CMAX) ? mcnt[i] + 1 : mcnt[i];
                mcnt[i] = (!enable || wend) ? 0 : c_new;
                if (wend && !e_busy) begin
                    ent.ch = i;
                    ent.rpm = scale(c_new);
                    mq.push_back(ent);
                end
            end
            if (wend && !e_busy) m_ready_at = mcyc + 9;
            if (wend && e_busy) m_ovr = 1;
            m_win = (!enable || wend) ? 0 : m_win + 1;
            if (e_valid && rpm_ready) begin
                void'(mq.pop_front());
                m_ready_at = mcyc + 9;
            end
        end
        mcyc++;
    end

    int dir_edges [9][NCH];
    int hold [NCH];

    function automatic logic tick_dir(input int ch, input int k);
        int w, off, per, n;
        w = k / WIN;
        off = k % WIN;
        if (ch == 0 && k >= 7999 && k <= 8001) return 1'b1;
        if (ch == 1 && k >= 8000 && k <= 8002) return 1'b1;
        if (w >= 9) return 1'b0;
        per = (w == 2) ? 2 : 4;
        n = dir_edges[w][ch];
        return (off >= 10 && off < 10 + per * n && ((off - 10) % per) < per / 2) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic ready_dir(input int k);
        return ((k >= 4008 && k < 4028) || (k >= 5000 && k < 6100)) ? 1'b0 : 1'b1;
    endfunction

    task automatic lit(input string name, input int v, input int r, input int ch);
        chk({name, "_valid"}, int'(rpm_valid), v);
        chk({name, "_rpm"}, int'(rpm), r);
        chk({name, "_ch"}, int'(rpm_ch), ch);
    endtask

    int waited, vcount;

    initial begin
        dir_edges = '{'{100, 40, 0, 0}, '{0, 0, 200, 0}, '{0, 0, 0, 400},
                      '{7, 13, 0, 0},   '{50, 0, 0, 0},  '{0, 30, 0, 0},
                      '{0, 20, 0, 0},   '{0, 0, 0, 0},   '{0, 0, 0, 0}};
        for (int i = 0; i < NCH; i++) hold[i] = 0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_overrun", int'(overrun), 0);
        lit("reset", 0, 0, 0);

        @(posedge clk); #1;
        rst = 1'b0;
        enable = 1'b1;
        for (int k = 0; k < 9100; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            for (int ch = 0; ch < NCH; ch++) ticks[ch] = tick_dir(ch, k);
            rpm_ready = ready_dir(k);
            case (k)
                1007: chk("first_pre_valid", int'(rpm_valid), 0);
                1008: lit("scale_ch0", 1, 150, 0);
                1017: lit("scale_ch1", 1, 60, 1);
                1026: lit("scale_ch2", 1, 0, 2);
                1035: lit("scale_ch3", 1, 0, 3);
                1036: chk("scale_busy_fall", int'(busy), 0);
                2026: lit("sat_clamp", 1, 255, 2);
                3035: lit("sat_counter", 1, 255, 3);
                4027: lit("bp_hold", 1, 10, 0);
                4037: lit("bp_resume", 1, 19, 1);
                6000: chk("overrun_set", int'(overrun), 1);
                6099: lit("ovr_old_ch0", 1, 75, 0);
                6109: lit("ovr_dropped_ch1", 1, 0, 1);
                7017: lit("after_ovr_ch1", 1, 30, 1);
                7100: chk("overrun_sticky", int'(overrun), 1);
                8008: lit("bound_close_ch0", 1, 1, 0);
                8017: lit("bound_close_ch1", 1, 0, 1);
                9008: lit("bound_next_ch0", 1, 0, 0);
                9017: lit("bound_next_ch1", 1, 1, 1);
                default: ;
            endcase
        end

        for (int r = 0; r < 3000; r++) begin
            @(posedge clk); #1;
            enable = (r >= 1500 && r < 1550) ? 1'b0 : 1'b1;
            rpm_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (hold[ch] >= 2 && $urandom_range(0, 2) == 0) begin
                    ticks[ch] = ~ticks[ch];
                    hold[ch] = 1;
                end else begin
                    hold[ch]++;
                end
            end
        end

        rpm_ready = 1'b0;
        enable = 1'b1;
        ticks = '0;
        waited = 0;
        while (!rpm_valid && waited < 3000) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("reach_out_state", int'(rpm_valid), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midout_busy", int'(busy), 0);
        chk("midout_overrun", int'(overrun), 0);
        chk("midout_rpm", int'(rpm), 0);
        chk("midout_valid", int'(rpm_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rpm_ready = 1'b1;
        vcount = 0;
        for (int k = 0; k < 1040; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            ticks[0] = (k >= 10 && k < 30 && ((k - 10) % 4) < 2) ? 1'b1 : 1'b0;
            if (k < 1008 && rpm_valid) vcount++;
            if (k == 1008) lit("post_rst_first", 1, 7, 0);
        end
        chk("post_rst_no_early_valid", vcount, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
